// File: rtl/edl_final_pkg.sv
// edl_final_pkg
//   Shared definitions for the on-chip memory arbiter slice:
//   default RAM geometry, FSM state encoding and the requester-index type.
package edl_final_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 32;

    // Arbiter FSM: zero-fill the RAM, then serve requesters.
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    typedef enum logic [0:0] {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_idx_t;

endpackage

// File: rtl/edl_final_rr_arbiter2.sv
// edl_final_rr_arbiter2
//   Two-way round-robin grant with its pointer register.
//   Ports:
//     clk, reset : clock and synchronous active-high reset (rr -> REQ_M0)
//     enable     : grant only while high (RUN state, reset low)
//     req[1:0]   : per-requester request
//     grant[1:0] : one-hot (or zero) grant, combinational
module edl_final_rr_arbiter2
    import edl_final_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    req_idx_t rr;

    // A lone requester always wins; rr only breaks ties.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (&req) begin
                grant[rr] = 1'b1;
            end else begin
                grant = req;
            end
        end
    end

    // Point at the requester that lost (or did not ask) after every grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr <= REQ_M0;
        end else if (|grant) begin
            rr <= grant[0] ? REQ_M1 : REQ_M0;
        end
    end

endmodule

// File: rtl/edl_final_onchip_memory_arbiter.sv
// edl_final_onchip_memory_arbiter
//   Shares one single-port on-chip RAM between two Avalon-MM style masters.
//   After reset the RAM is optionally zero-filled (CLEAR), then requests are
//   granted round-robin, one per cycle (RUN).
//   Ports:
//     clk, reset                : clock, synchronous active-high reset
//     m0_* / m1_*               : requester side (address, byteenable, read,
//                                 write, writedata in; waitrequest, readdata,
//                                 readdatavalid out)
//     mem_*                     : RAM side; readdata returns 1 cycle after
//                                 the address is presented
module edl_final_onchip_memory_arbiter
    import edl_final_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam logic [0:0] RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clearing;
    logic              running;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              gnt_any;
    logic              gnt_write;
    logic              gnt_read;
    req_idx_t          sel;
    logic              rd_vld_p0;
    req_idx_t          rd_own_p0;

    assign clearing = (state == ST_CLEAR) && !reset;
    assign running  = (state == ST_RUN) && !reset;
    assign req      = {m1_read | m1_write, m0_read | m0_write};

    edl_final_rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .enable (running),
        .req    (req),
        .grant  (grant)
    );

    assign sel       = grant[1] ? REQ_M1 : REQ_M0;
    assign gnt_any   = |grant;
    // Write wins if a master illegally raises read and write together.
    assign gnt_write = grant[1] ? m1_write : m0_write;
    assign gnt_read  = gnt_any && !gnt_write;

    assign mem_clken = 1'b1;

    always_comb begin
        mem_address    = grant[1] ? m1_address    : m0_address;
        mem_byteenable = grant[1] ? m1_byteenable : m0_byteenable;
        mem_writedata  = grant[1] ? m1_writedata  : m0_writedata;
        mem_chipselect = gnt_any;
        mem_write      = gnt_any && gnt_write;
        if (clearing) begin
            mem_address    = clr_cnt;
            mem_byteenable = '1;
            mem_writedata  = '0;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
        end
    end

    // grant is forced to zero outside RUN, so both masters stall there.
    assign m0_waitrequest = !grant[0];
    assign m1_waitrequest = !grant[1];

    assign m0_readdata = mem_readdata;
    assign m1_readdata = mem_readdata;

    // Gating with reset drops a read granted the cycle before reset rose.
    assign m0_readdatavalid = rd_vld_p0 && (rd_own_p0 == REQ_M0) && !reset;
    assign m1_readdatavalid = rd_vld_p0 && (rd_own_p0 == REQ_M1) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RESET_STATE;
            clr_cnt   <= '0;
            rd_vld_p0 <= 1'b0;
        end else begin
            rd_vld_p0 <= gnt_read;
            if (clearing) begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
                if (clr_cnt == '1) begin
                    state <= ST_RUN;
                end
            end
        end
    end

    // ---- stage p0: read owner, lines up with RAM output ----
    always_ff @(posedge clk) begin
        rd_own_p0 <= sel;
    end

endmodule

// File: tb/tb_edl_final_onchip_memory_arbiter.sv
module tb_edl_final_onchip_memory_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] m0_address, m1_address;
    logic [3:0]    m0_byteenable, m1_byteenable;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    edl_final_onchip_memory_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // RAM model: registered read, write lands at the issuing clock edge.
    // Pre-filled with a non-zero pattern so the zero-fill is observable.
    logic [DW-1:0] ram [0:DEPTH-1];
    logic          ram_filled = 1'b0;

    always @(posedge clk) begin
        if (!ram_filled) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 32'hA5A5_A5A5;
            ram_filled <= 1'b1;
        end else if (mem_clken) begin
            if (mem_chipselect && mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n, input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] be);
        if (n == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Single-cycle write; returns at the start of the following cycle.
    task automatic do_write(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] be);
        drive(n, 1'b0, 1'b1, a, d, be);
        @(negedge clk);
        check_eq("wr_wait", 32'((n == 0) ? m0_waitrequest : m1_waitrequest), 32'd0);
        check_eq("wr_cs_we", 32'({mem_chipselect, mem_write}), 32'b11);
        check_eq("wr_addr", 32'(mem_address), 32'(a));
        next_cycle();
        idle_all();
    endtask

    // Single read; checks the data and that only the owner sees readdatavalid.
    task automatic do_read(input int n, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        drive(n, 1'b1, 1'b0, a, '0, '0);
        @(negedge clk);
        check_eq("rd_wait", 32'((n == 0) ? m0_waitrequest : m1_waitrequest), 32'd0);
        check_eq("rd_cs_we", 32'({mem_chipselect, mem_write}), 32'b10);
        check_eq("rd_no_early_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
        next_cycle();
        idle_all();
        @(negedge clk);
        check_eq("rd_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), (n == 0) ? 32'b01 : 32'b10);
        check_eq("rd_data", (n == 0) ? m0_readdata : m1_readdata, exp);
        next_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int bad;
        reset = 1'b1;
        idle_all();
        // m0 holds a read of 0x1234 through reset and the whole clear.
        drive(0, 1'b1, 1'b0, 14'h1234, '0, '0);
        @(negedge clk);
        check_eq("rst_wait", 32'({m1_waitrequest, m0_waitrequest}), 32'b11);
        check_eq("rst_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
        check_eq("rst_cs_we", 32'({mem_chipselect, mem_write}), 32'd0);
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Zero-fill: one write per cycle to 0..DEPTH-1, masters stalled.
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (!(mem_chipselect && mem_write && mem_address == AW'(i) && mem_writedata == '0 &&
                  mem_byteenable == 4'hF && m0_waitrequest && m1_waitrequest)) bad++;
            next_cycle();
        end
        check_eq("clear_bad_cycles", 32'(bad), 32'd0);

        // First RUN cycle: the held read is granted and returns zero.
        @(negedge clk);
        check_eq("run_m0_wait", 32'(m0_waitrequest), 32'd0);
        check_eq("run_addr", 32'(mem_address), 32'h1234);
        check_eq("run_cs_we", 32'({mem_chipselect, mem_write}), 32'b10);
        next_cycle();
        idle_all();
        @(negedge clk);
        check_eq("zero_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'b01);
        check_eq("zero_data", m0_readdata, 32'h0);
        next_cycle();

        // Distinct data for the contention test.
        do_write(0, 14'h0040, 32'h4040_4040, 4'hF);
        do_write(1, 14'h0041, 32'h4141_4141, 4'hF);

        // m1 alone for 3 cycles: never stalled; leaves rr pointing at m0.
        for (int j = 0; j < 3; j++) begin
            drive(1, 1'b1, 1'b0, AW'(16'h0100 + j), '0, '0);
            @(negedge clk);
            check_eq("solo_m1_wait", 32'(m1_waitrequest), 32'd0);
            check_eq("solo_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), (j == 0) ? 32'b00 : 32'b10);
            next_cycle();
        end
        idle_all();
        @(negedge clk);
        check_eq("solo_last_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'b10);
        next_cycle();

        // Both read for 4 cycles from rr = m0: m0, m1, m0, m1.
        drive(0, 1'b1, 1'b0, 14'h0040, '0, '0);
        drive(1, 1'b1, 1'b0, 14'h0041, '0, '0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check_eq("rr_wait", 32'({m1_waitrequest, m0_waitrequest}), (j % 2 == 0) ? 32'b10 : 32'b01);
            check_eq("rr_addr", 32'(mem_address), (j % 2 == 0) ? 32'h40 : 32'h41);
            if (j > 0) begin
                check_eq("rr_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), (j % 2 == 1) ? 32'b01 : 32'b10);
                check_eq("rr_data", m0_readdata, (j % 2 == 1) ? 32'h4040_4040 : 32'h4141_4141);
            end
            next_cycle();
        end
        idle_all();
        @(negedge clk);
        check_eq("rr_tail_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'b10);
        check_eq("rr_tail_data", m1_readdata, 32'h4141_4141);
        next_cycle();

        // Write then read from the other master on the very next cycle.
        do_write(0, 14'h0010, 32'hDEAD_BEEF, 4'hF);
        do_read(1, 14'h0010, 32'hDEAD_BEEF);

        // Partial byte-enable merge.
        do_write(0, 14'h0020, 32'h1111_1111, 4'hF);
        do_write(1, 14'h0020, 32'hAABB_CCDD, 4'h3);
        do_read(0, 14'h0020, 32'h1111_CCDD);

        // Read and write together: write wins, no readdatavalid.
        drive(0, 1'b1, 1'b1, 14'h0030, 32'h1234_5678, 4'hF);
        @(negedge clk);
        check_eq("rw_mem_write", 32'(mem_write), 32'd1);
        next_cycle();
        idle_all();
        @(negedge clk);
        check_eq("rw_no_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
        next_cycle();
        do_read(0, 14'h0030, 32'h1234_5678);

        // Reset right after an m1 read grant drops its readdatavalid.
        drive(1, 1'b1, 1'b0, 14'h0010, '0, '0);
        @(negedge clk);
        check_eq("pre_rst_m1_wait", 32'(m1_waitrequest), 32'd0);
        next_cycle();
        idle_all();
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_drop_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
        check_eq("rst2_wait", 32'({m1_waitrequest, m0_waitrequest}), 32'b11);
        check_eq("rst2_cs_we", 32'({mem_chipselect, mem_write}), 32'd0);
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("reclear_addr", 32'({mem_chipselect, mem_write, mem_address}), 32'({2'b11, AW'(i)}));
            next_cycle();
        end

        // Reset mid-clear restarts at address 0.
        reset = 1'b1;
        @(negedge clk);
        check_eq("midclr_rst_cs", 32'({mem_chipselect, mem_write}), 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_eq("midclr_restart", 32'({mem_chipselect, mem_write, mem_address}), 32'({2'b11, AW'(0)}));
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
